mc_port_responder: RTL



---
 rtl/mc_msg_pkg.sv | 43 ++++
 rtl/mc_resp_fifo.sv | 68 ++++++
 rtl/mc_port_responder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mc_msg_pkg.sv
// Command and size encodings of the mc_rq_*/mc_rs_* interface, shared with
// requester models, plus the request classifier used by the responder.
package mc_msg_pkg;

    // Request commands
    localparam logic [2:0] RD      = 3'd1;
    localparam logic [2:0] WR      = 3'd2;

    // Response commands
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_CMP  = 3'd3;

    // The only supported request size and sub-command
    localparam logic [1:0] SZ_8B     = 2'd3;
    localparam logic [3:0] SCMD_NONE = 4'd0;

    typedef enum logic [1:0] {
        RQ_NONE  = 2'd0,
        RQ_READ  = 2'd1,
        RQ_WRITE = 2'd2,
        RQ_BAD   = 2'd3
    } rq_kind_e;

    // Classify one request beat; anything not an 8-byte plain RD/WR is RQ_BAD.
    function automatic rq_kind_e rq_decode(input logic       vld,
                                           input logic [2:0] cmd,
                                           input logic [3:0] scmd,
                                           input logic [1:0] size);
        rq_kind_e kind;
        kind = RQ_BAD;
        if (!vld) begin
            kind = RQ_NONE;
        end else if (scmd == SCMD_NONE && size == SZ_8B) begin
            if (cmd == RD) begin
                kind = RQ_READ;
            end else if (cmd == WR) begin
                kind = RQ_WRITE;
            end
        end
        return kind;
    endfunction

endpackage

// File: rtl/mc_resp_fifo.sv
// Synchronous response FIFO with occupancy and free-entry counts. A push and a
// pop in the same cycle leave the count unchanged; when empty, such a pair
// passes the pushed word straight through to dout.
module mc_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count,
    output logic [AW:0]      free
);

    localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             bypass;
    logic             do_wr;
    logic             do_rd;

    // Write/read qualification; a push into a full FIFO only lands if a pop frees a slot
    always_comb begin
        empty  = (count == '0);
        full   = (count == DEPTH);
        free   = DEPTH - count;
        bypass = empty && push && pop;
        do_wr  = push && !bypass && (!full || pop);
        do_rd  = pop && !empty;
        dout   = empty ? din : store[rd_ptr];
    end

    // Storage array; data words need no reset
    always_ff @(posedge clk) begin
        if (do_wr) begin
            store[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mc_port_responder.sv
// MC end of one mc_rq_*/mc_rs_* port: a word-addressed local memory answering
// 8-byte reads and writes in request order. Request path: decode -> memory
// access + enqueue stage -> response FIFO -> output stage held under
// mc_rs_stall. Also tracks flush completion and sticky error flags.
module mc_port_responder
    import mc_msg_pkg::*;
#(
    parameter int RTNCTL_WIDTH = 32,
    parameter int MEM_AW       = 10,
    parameter int FIFO_AW      = 4,
    parameter int STALL_SLACK  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mc_rq_vld,
    input  logic [2:0]              mc_rq_cmd,
    input  logic [3:0]              mc_rq_scmd,
    input  logic [1:0]              mc_rq_size,
    input  logic [47:0]             mc_rq_vadr,
    input  logic [63:0]             mc_rq_data,
    input  logic [RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
    output logic                    mc_rq_stall,
    output logic                    mc_rs_vld,
    output logic [2:0]              mc_rs_cmd,
    output logic [3:0]              mc_rs_scmd,
    output logic [63:0]             mc_rs_data,
    output logic [RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
    input  logic                    mc_rs_stall,
    input  logic                    mc_rq_flush,
    output logic                    mc_rs_flush_cmplt,
    output logic                    err_ovf,
    output logic                    err_cmd
);

    localparam int ENTRY_W = 3 + 64 + RTNCTL_WIDTH;
    localparam int STALL_AT = STALL_SLACK + 1;

    rq_kind_e rq_kind;
    logic [MEM_AW-1:0] rq_idx;
    logic unused_vadr;
    logic fifo_room;
    logic accept_rd;
    logic accept_wr;
    logic drop_ovf;

    logic [63:0] mem [2**MEM_AW];
    logic [63:0] rd_q;

    logic                    enq_vld;
    logic [2:0]              enq_cmd;
    logic [RTNCTL_WIDTH-1:0] enq_rtnctl;
    logic [63:0]             enq_data;

    logic [ENTRY_W-1:0] fifo_din;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               fifo_empty;
    logic               fifo_full;
    logic [FIFO_AW:0]   fifo_count;
    logic [FIFO_AW:0]   fifo_free;
    logic               fifo_pop;

    logic                    out_vld;
    logic [2:0]              out_cmd;
    logic [63:0]             out_data;
    logic [RTNCTL_WIDTH-1:0] out_rtnctl;
    logic                    out_load;

    logic flush_pending;
    logic flush_done;

    // Request decode; room is judged against the FIFO plus the word already in the enqueue stage
    always_comb begin
        rq_kind     = rq_decode(mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_size);
        rq_idx      = mc_rq_vadr[MEM_AW+2:3];
        unused_vadr = ^{mc_rq_vadr[47:MEM_AW+3], mc_rq_vadr[2:0], fifo_full, fifo_count};
        fifo_room   = (fifo_free > (FIFO_AW+1)'(enq_vld));
        accept_rd   = (rq_kind == RQ_READ)  && fifo_room;
        accept_wr   = (rq_kind == RQ_WRITE) && fifo_room;
        drop_ovf    = (rq_kind == RQ_READ || rq_kind == RQ_WRITE) && !fifo_room;
        mc_rq_stall = (int'(fifo_free) <= STALL_AT + int'(enq_vld));
    end

    // Local memory: write and read both happen at the acceptance edge; contents survive reset
    always_ff @(posedge clk) begin
        if (accept_wr) begin
            mem[rq_idx] <= mc_rq_data;
        end
        if (accept_rd) begin
            rd_q <= mem[rq_idx];
        end
    end

    // Enqueue stage: holds the response for one cycle while the read data settles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enq_vld    <= 1'b0;
            enq_cmd    <= '0;
            enq_rtnctl <= '0;
        end else begin
            enq_vld    <= accept_rd || accept_wr;
            enq_cmd    <= accept_rd ? RD_DATA : WR_CMP;
            enq_rtnctl <= mc_rq_rtnctl;
        end
    end

    // Response word and output-stage advance; the head is only taken when the stage can move
    always_comb begin
        enq_data = (enq_cmd == RD_DATA) ? rd_q : 64'd0;
        fifo_din = {enq_cmd, enq_data, enq_rtnctl};
        out_load = !out_vld || !mc_rs_stall;
        fifo_pop = out_load && !fifo_empty;
    end

    mc_resp_fifo #(
        .WIDTH (ENTRY_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (enq_vld),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count),
        .free  (fifo_free)
    );

    // Output stage: holds its response while the requester stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld    <= 1'b0;
            out_cmd    <= '0;
            out_data   <= '0;
            out_rtnctl <= '0;
        end else if (out_load) begin
            out_vld <= !fifo_empty;
            if (!fifo_empty) begin
                {out_cmd, out_data, out_rtnctl} <= fifo_dout;
            end else begin
                out_cmd    <= '0;
                out_data   <= '0;
                out_rtnctl <= '0;
            end
        end
    end

    always_comb begin
        mc_rs_vld    = out_vld;
        mc_rs_cmd    = out_cmd;
        mc_rs_scmd   = 4'd0;
        mc_rs_data   = out_data;
        mc_rs_rtnctl = out_rtnctl;
    end

    // Flush completes once nothing is queued and the last response leaves (or none is held)
    always_comb begin
        flush_done = flush_pending && !enq_vld && fifo_empty &&
                     (!out_vld || !mc_rs_stall);
        mc_rs_flush_cmplt = flush_done;
    end

    // Flush tracker; a flush arriving while one is pending is absorbed into it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_pending <= 1'b0;
        end else if (mc_rq_flush) begin
            flush_pending <= 1'b1;
        end else if (flush_done) begin
            flush_pending <= 1'b0;
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_ovf <= 1'b0;
            err_cmd <= 1'b0;
        end else begin
            if (drop_ovf) begin
                err_ovf <= 1'b1;
            end
            if (rq_kind == RQ_BAD) begin
                err_cmd <= 1'b1;
            end
        end
    end

endmodule
